// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence link: the default pattern
// (also used by the detector) and the one-hot transmitter state encoding.
package seq_pkg;

  localparam int              SEQ_PAT_W   = 6;
  localparam logic [SEQ_PAT_W-1:0] SEQ_PATTERN = 6'b110101;

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    SEND = 4'b0010,
    GAP  = 4'b0100,
    DONE = 4'b1000
  } tx_state_t;

endpackage

// File: rtl/seq_dn_counter.sv
// Loadable down-counter with a zero flag; load takes priority over decrement.
module seq_dn_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     count <= '0;
    else if (load) count <= load_val;
    else if (dec)  count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends PATTERN MSB-first for a programmable
// number of repetitions, optionally separated by gap_len zero bits.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int                   PATTERN_W = SEQ_PAT_W,
  parameter logic [PATTERN_W-1:0] PATTERN   = SEQ_PATTERN,
  parameter int                   REP_W     = 4,
  parameter int                   GAP_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [REP_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
  input  logic             abort,
  output logic             x_out,
  output logic             x_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (PATTERN_W > 2) ? $clog2(PATTERN_W) : 1;

  tx_state_t        state, state_nxt;
  logic [IDX_W-1:0] bit_idx, idx_m1;
  logic [REP_W-1:0] rep_rem, rep_load_val;
  logic [GAP_W-1:0] gap_cnt, gap_q;
  logic             idx_zero, rep_zero, gap_zero;
  logic             idx_load, idx_dec, rep_load, rep_dec, gap_load, gap_dec;
  logic             x_nxt, vld_nxt, fs_nxt, busy_nxt, done_nxt;

  // bit_idx holds the index of the bit currently on x_out; rep_rem counts
  // repetitions still to send after the current one.
  seq_dn_counter #(.W(IDX_W)) u_idx (
    .clk(clk), .reset(reset), .load(idx_load), .load_val(IDX_W'(PATTERN_W - 1)),
    .dec(idx_dec), .count(bit_idx), .zero(idx_zero)
  );

  seq_dn_counter #(.W(REP_W)) u_rep (
    .clk(clk), .reset(reset), .load(rep_load), .load_val(rep_load_val),
    .dec(rep_dec), .count(rep_rem), .zero(rep_zero)
  );

  seq_dn_counter #(.W(GAP_W)) u_gap (
    .clk(clk), .reset(reset), .load(gap_load), .load_val(gap_q - 1'b1),
    .dec(gap_dec), .count(gap_cnt), .zero(gap_zero)
  );

  assign rep_load_val = (repeat_cnt == '0) ? '0 : repeat_cnt - 1'b1;
  assign idx_m1       = bit_idx - 1'b1;

  always_ff @(posedge clk) begin
    if (state == IDLE && start) gap_q <= gap_len;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      x_out       <= 1'b0;
      x_valid     <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      x_out       <= x_nxt;
      x_valid     <= vld_nxt;
      frame_start <= fs_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_load  = 1'b0;
    idx_dec   = 1'b0;
    rep_load  = 1'b0;
    rep_dec   = 1'b0;
    gap_load  = 1'b0;
    gap_dec   = 1'b0;
    x_nxt     = 1'b0;
    vld_nxt   = 1'b0;
    fs_nxt    = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SEND;
          idx_load  = 1'b1;
          rep_load  = 1'b1;
          x_nxt     = PATTERN[PATTERN_W-1];
          vld_nxt   = 1'b1;
          fs_nxt    = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      SEND: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (!idx_zero) begin
          idx_dec  = 1'b1;
          x_nxt    = PATTERN[idx_m1];
          vld_nxt  = 1'b1;
          busy_nxt = 1'b1;
        end else if (rep_zero) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else if (gap_q != '0) begin
          state_nxt = GAP;
          gap_load  = 1'b1;
          busy_nxt  = 1'b1;
        end else begin
          // back-to-back repetition: restart the pattern without a gap
          idx_load = 1'b1;
          rep_dec  = 1'b1;
          x_nxt    = PATTERN[PATTERN_W-1];
          vld_nxt  = 1'b1;
          fs_nxt   = 1'b1;
          busy_nxt = 1'b1;
        end
      end
      GAP: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (gap_zero) begin
          state_nxt = SEND;
          idx_load  = 1'b1;
          rep_dec   = 1'b1;
          x_nxt     = PATTERN[PATTERN_W-1];
          vld_nxt   = 1'b1;
          fs_nxt    = 1'b1;
          busy_nxt  = 1'b1;
        end else begin
          gap_dec  = 1'b1;
          busy_nxt = 1'b1;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: per-cycle expected output vectors are
// queued when a burst is launched and compared on the falling edge.
module tb_seq_pattern_tx;

  localparam logic [5:0] PAT = 6'b110101;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] repeat_cnt;
  logic [3:0] gap_len;
  logic       abort;
  logic       x_out, x_valid, frame_start, busy, done;

  logic [4:0] expq[$];
  int         total = 0;
  int         bad   = 0;
  logic [5:0] sh    = '0;
  int         hits  = 0;
  int         h0;

  seq_pattern_tx dut (
    .clk(clk), .reset(reset), .start(start), .repeat_cnt(repeat_cnt),
    .gap_len(gap_len), .abort(abort), .x_out(x_out), .x_valid(x_valid),
    .frame_start(frame_start), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference overlapping 110101 detector fed straight from x_out.
  always @(posedge clk) begin
    sh <= {sh[4:0], x_out};
    if (sh == PAT) hits <= hits + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // vector layout: {x_out, x_valid, frame_start, busy, done}
  task automatic push_burst(input int r, input int g);
    int eff;
    eff = (r == 0) ? 1 : r;
    for (int k = 0; k < eff; k++) begin
      for (int b = 5; b >= 0; b--) expq.push_back({PAT[b], 1'b1, b == 5, 1'b1, 1'b0});
      if (k < eff - 1)
        for (int j = 0; j < g; j++) expq.push_back(5'b00010);
    end
    expq.push_back(5'b00001);
    expq.push_back(5'b00000);
  endtask

  task automatic launch(input int r, input int g);
    @(negedge clk);
    repeat_cnt = 4'(r);
    gap_len    = 4'(g);
    start      = 1'b1;
  endtask

  task automatic drain(input string tag, input int start_at, input int abort_at);
    int i;
    i = 0;
    while (expq.size() > 0) begin
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, i), {27'd0, x_out, x_valid, frame_start, busy, done},
            {27'd0, expq.pop_front()});
      start = (i == start_at);
      abort = (i == abort_at);
      i++;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; repeat_cnt = '0; gap_len = '0;
    repeat (2) @(negedge clk);
    check("reset_outs", {27'd0, x_out, x_valid, frame_start, busy, done}, 32'd0);
    reset = 1'b0;

    // single frame
    launch(1, 0); push_burst(1, 0); drain("single", -1, -1);
    // three reps with 2-cycle gap
    launch(3, 2); push_burst(3, 2); drain("gap2", -1, -1);
    // back-to-back pair
    launch(2, 0); push_burst(2, 0); drain("b2b", -1, -1);
    // zero reps behaves as one
    launch(0, 5); push_burst(1, 5); drain("rep0", -1, -1);

    // abort while showing the 3rd bit
    launch(2, 1);
    for (int b = 5; b >= 3; b--) expq.push_back({PAT[b], 1'b1, b == 5, 1'b1, 1'b0});
    expq.push_back(5'b00000);
    expq.push_back(5'b00000);
    drain("abort", -1, 2);

    // start pulsed mid-burst is ignored
    launch(2, 1); push_burst(2, 1); drain("start_busy", 4, -1);

    // start with simultaneous abort in IDLE: start wins
    launch(1, 0); abort = 1'b1; push_burst(1, 0); drain("start_abort", -1, -1);

    // async reset in the middle of a gap
    launch(3, 3);
    repeat (8) @(negedge clk);
    start = 1'b0;
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    check("pre_reset_valid", {31'd0, x_valid}, 32'd0);
    #1 reset = 1'b1;
    #1 check("async_reset", {27'd0, x_out, x_valid, frame_start, busy, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    launch(1, 2); push_burst(1, 2); drain("after_reset", -1, -1);

    // loopback into the reference detector
    for (int gi = 0; gi < 3; gi++) begin
      int g;
      g  = (gi == 0) ? 0 : (gi == 1) ? 1 : 3;
      h0 = hits;
      launch(4, g); push_burst(4, g); drain($sformatf("loop_g%0d", g), -1, -1);
      check($sformatf("loop_hits_g%0d", g), 32'(hits - h0), 32'd4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial pattern transmitter. Emits a fixed bit pattern (default 110101, MSB first), one bit per clk, for a programmable number of repetitions. Repetitions are separated by an optional programmable gap of zero bits. The block is the stimulus/transmit end of the serial sequence-detector link: its x_out drives a detector's x input directly. It uses a Moore FSM with registered outputs.

Parameters:
PATTERN_W, 6, pattern length in bits (2..16)
PATTERN, 6'b110101, bit pattern; bit PATTERN_W-1 is sent first
REP_W, 4, width of repeat_cnt
GAP_W, 4, width of gap_len

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-high; forces IDLE and all outputs to reset values
start  input  1  request a burst; sampled only in IDLE
repeat_cnt  input  REP_W  number of pattern transmissions; 0 is treated as 1; latched on accepted start
gap_len  input  GAP_W  zero-bit cycles between repetitions; latched on accepted start
abort  input  1  synchronous cancel of a burst in progress
x_out  output  1  serial data bit
x_valid  output  1  high while x_out carries a pattern bit
frame_start  output  1  high on the cycle carrying bit PATTERN_W-1 of each repetition
busy  output  1  high from first bit through last gap/bit
done  output  1  one-cycle pulse after a burst completes normally

Behaviour:
- Reset values: x_out=0, x_valid=0, frame_start=0, busy=0, done=0. All are registered outputs.
- States: IDLE, SEND, GAP, DONE (one-hot).
- IDLE:
  - If start=1 at edge k: latch reps (repeat_cnt, with 0 mapped to 1) and gap_len; load bit index = PATTERN_W-1; go to SEND.
  - From edge k: x_out=PATTERN[W-1], x_valid=1, frame_start=1, busy=1.
  - Latency is 1 cycle from start sample to first bit.
- SEND:
  - Each edge presents the next lower pattern bit; frame_start=0 after the first bit.
  - After bit 0, on the same edge:
    - Remaining reps>0 and gap>0: go to GAP.
    - Remaining reps>0 and gap=0: go to SEND with index reloaded; the next pattern follows back-to-back with frame_start=1.
    - Remaining reps=0: go to DONE.
- GAP:
  - Lasts exactly gap_len cycles: x_out=0, x_valid=0, busy=1.
  - Then go to SEND with frame_start=1.
- DONE:
  - Lasts exactly 1 cycle: done=1, busy=0, x_valid=0, x_out=0.
  - Then go to IDLE.
  - start is ignored in DONE and in all non-IDLE states; it is not queued.
- abort=1 in SEND/GAP: go to IDLE at the next edge with all outputs at reset values. No done pulse. Latched counts are discarded. abort in IDLE/DONE has no effect.
- Simultaneous start and abort in IDLE: start wins; abort is only sampled outside IDLE.
- reset mid-burst: outputs go to reset values immediately (asynchronous). No done pulse.
- A burst lasts R*PATTERN_W + (R-1)*gap_len cycles of busy=1, where R is the effective rep count. Counters saturate at no point; wrap is impossible by construction.
- Loopback contract: with x_out wired to an overlapping detector for 110101, every repetition produces exactly one detector y pulse. This holds for any gap_len, including 0.

Decomposition:
- Shared package seq_pkg:
  - Default pattern constant (110101) and its width, shared with the detector.
  - One-hot state localparams IDLE/SEND/GAP/DONE.
- Sub-module: seq_dn_counter (loadable down-counter with zero flag), instantiated three times: bit index, rep count, gap count.

Test Plan:
- Single frame: reset, then start=1 with repeat_cnt=1, gap_len=0.
  - x_out = 1,1,0,1,0,1 on the 6 cycles after start, x_valid=1 throughout, frame_start only on the first bit.
  - done=1 on cycle 7; busy=1 for exactly 6 cycles.
- Repetition with gap: repeat_cnt=3, gap_len=2.
  - Sequence is 110101,00,110101,00,110101; busy=22 cycles; three frame_start pulses; one done.
- Back-to-back and zero reps:
  - repeat_cnt=2, gap_len=0: 12 consecutive valid bits, frame_start at cycles 1 and 7.
  - repeat_cnt=0: behaves exactly as repeat_cnt=1.
- Abort and start-while-busy:
  - abort at the 3rd bit: x_valid=0 and busy=0 next cycle, no done.
  - start pulsed mid-burst: ignored; burst length unchanged.
- Async reset mid-GAP: all outputs 0 immediately, state IDLE. A following start sends a full frame from the first bit.
- Loopback into the detector: repeat_cnt=4, gap_len in {0,1,3}. The detector's y pulses exactly 4 times, each 2 cycles after the last bit of a frame.
